// File: rtl/orb_window_gen.sv
// orb_window_gen: line-buffer window generator for the ORB/BRIEF path.
// Keeps WIN-1 previous lines in line buffers plus a WIN x WIN register
// window. It emits one full neighbourhood per accepted pixel, together with
// the window-centre coordinates. Windows that are not fully inside the
// current frame are masked.
module orb_window_gen #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WIN   = 31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vs,
    input  logic                       in_hs,
    input  logic                       in_en,
    input  logic [PIX_W-1:0]           in_pix,
    output logic                       out_vs,
    output logic                       out_hs,
    output logic                       out_en,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic [WIN*WIN*PIX_W-1:0]   out_window
);

    localparam int ROW_W    = $clog2(IMG_H);
    localparam int COL_W    = $clog2(IMG_W);
    localparam int NBUF     = WIN - 1;
    localparam int WIN_BITS = WIN * WIN * PIX_W;

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_HALF  = ROW_W'((WIN - 1) / 2);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN - 1);
    localparam logic [COL_W-1:0] COL_HALF  = COL_W'((WIN - 1) / 2);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);

    // Position counters and frame state
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_frame_done;

    // Sync delay line; r_vs_d1 doubles as the frame-start edge detector
    logic               r_vs_d1;
    logic               r_vs_d2;
    logic               r_hs_d1;
    logic               r_hs_d2;

    // Stage-0 pipeline registers
    logic               r_v_d1;
    logic [PIX_W-1:0]   r_pix_d1;
    logic [COL_W-1:0]   r_col_d1;
    logic [ROW_W-1:0]   r_row_d1;

    // Line buffers and their synchronous read data
    logic [PIX_W-1:0]   r_lbuf [NBUF][IMG_W];
    logic [PIX_W-1:0]   r_rd   [NBUF];

    // Working window and registered outputs
    logic [WIN_BITS-1:0] r_win;
    logic                r_out_en;
    logic [ROW_W-1:0]    r_out_row;
    logic [COL_W-1:0]    r_out_col;
    logic [WIN_BITS-1:0] r_out_window;

    logic                w_vs_rise;
    logic                w_acc;
    logic [COL_W-1:0]    w_pos_col;
    logic [ROW_W-1:0]    w_pos_row;
    logic [WIN_BITS-1:0] w_win_next;
    logic                w_win_ok;

    // Frame-start detection, pixel acceptance and effective pixel position
    always_comb begin
        w_vs_rise = in_vs & ~r_vs_d1;
        w_acc     = in_en & (w_vs_rise | ~r_frame_done);
        if (w_vs_rise) begin
            w_pos_col = '0;
            w_pos_row = '0;
        end else begin
            w_pos_col = r_col;
            w_pos_row = r_row;
        end
    end

    // Column/row counters; frame_done freezes intake after the last pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else if (w_acc) begin
            if (w_pos_col == COL_LAST) begin
                r_col <= '0;
                if (w_pos_row == ROW_LAST) begin
                    r_row        <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_row        <= w_pos_row + ROW_ONE;
                    r_frame_done <= 1'b0;
                end
            end else begin
                r_col        <= w_pos_col + COL_ONE;
                r_row        <= w_pos_row;
                r_frame_done <= 1'b0;
            end
        end else if (w_vs_rise) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end
    end

    // Two-cycle delay of the sync signals
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d1 <= 1'b0;
            r_vs_d2 <= 1'b0;
            r_hs_d1 <= 1'b0;
            r_hs_d2 <= 1'b0;
        end else begin
            r_vs_d1 <= in_vs;
            r_vs_d2 <= r_vs_d1;
            r_hs_d1 <= in_hs;
            r_hs_d2 <= r_hs_d1;
        end
    end

    // Stage 0: capture accepted pixel, its position and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_d1   <= 1'b0;
            r_pix_d1 <= '0;
            r_col_d1 <= '0;
            r_row_d1 <= '0;
        end else begin
            r_v_d1 <= w_acc;
            if (w_acc) begin
                r_pix_d1 <= in_pix;
                r_col_d1 <= w_pos_col;
                r_row_d1 <= w_pos_row;
            end
        end
    end

    // Stage 0: synchronous read of every line buffer at the incoming column
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int k = 0; k < NBUF; k++) begin
                r_rd[k] <= r_lbuf[k][w_pos_col];
            end
        end
    end

    // Stage 1: push the column down the buffer chain (new pixel into buffer 0)
    always_ff @(posedge clk) begin
        if (r_v_d1) begin
            r_lbuf[0][r_col_d1] <= r_pix_d1;
            for (int k = 1; k < NBUF; k++) begin
                r_lbuf[k][r_col_d1] <= r_rd[k-1];
            end
        end
    end

    // Next window: shift left one column, new right column from buffers/pixel
    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                w_win_next[(r*WIN + c)*PIX_W +: PIX_W] = r_win[(r*WIN + c + 1)*PIX_W +: PIX_W];
            end
        end
        for (int k = 0; k < NBUF; k++) begin
            w_win_next[((WIN - 2 - k)*WIN + WIN - 1)*PIX_W +: PIX_W] = r_rd[k];
        end
        w_win_next[((WIN - 1)*WIN + WIN - 1)*PIX_W +: PIX_W] = r_pix_d1;
        w_win_ok = r_v_d1 && (r_row_d1 >= ROW_FIRST) && (r_col_d1 >= COL_FIRST);
    end

    // Stage 1: update working window; publish only fully-valid windows
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win        <= '0;
            r_out_en     <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_out_window <= '0;
        end else begin
            if (r_v_d1) begin
                r_win <= w_win_next;
            end
            r_out_en <= w_win_ok;
            if (w_win_ok) begin
                r_out_row    <= r_row_d1 - ROW_HALF;
                r_out_col    <= r_col_d1 - COL_HALF;
                r_out_window <= w_win_next;
            end
        end
    end

    assign out_vs     = r_vs_d2;
    assign out_hs     = r_hs_d2;
    assign out_en     = r_out_en;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign out_window = r_out_window;

endmodule

// File: doc/orb_window_gen.md
Name: orb_window_gen

Overview:
- Line-buffer window generator for the ORB/BRIEF path.
- Takes a raster grey-pixel stream and keeps WIN-1 previous lines in line buffers plus a WIN x WIN register window.
- Presents the full WIN x WIN neighbourhood, one window per accepted pixel, to the downstream BRIEF descriptor stage.
- Also outputs the image coordinates of the window centre.

Parameters:
- PIX_W, 8, pixel/brightness width.
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame.
- WIN, 31, window side (odd, 3..31).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_vs  input  1  frame sync, level; rising edge marks frame start
- in_hs  input  1  line sync, passed through only
- in_en  input  1  pixel valid
- in_pix  input  PIX_W  pixel brightness
- out_vs  output  1  in_vs delayed 2 cycles
- out_hs  output  1  in_hs delayed 2 cycles
- out_en  output  1  window valid, 1-cycle pulse per valid window
- out_row  output  $clog2(IMG_H)  centre row of current window
- out_col  output  $clog2(IMG_W)  centre column of current window
- out_window  output  WIN*WIN*PIX_W  element (r,c) at bits [(r*WIN+c)*PIX_W +: PIX_W]

Behaviour:
- Single clock domain: clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - The col/row counters, window registers and pipeline valids are 0.
  - Line-buffer contents are don't-care.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the incoming pixel.
  - Both advance only on an accepted pixel.
  - col wraps to 0 at IMG_W-1 and row then increments.
  - After pixel (IMG_H-1, IMG_W-1), set a frame_done flag. Further in_en is ignored: no counter, buffer or window change, no out_en.
- An in_vs rising edge (registered 0->1 compare) clears col, row and frame_done in that cycle.
  - An in_en in the same cycle is accepted as pixel (0,0).
  - Line buffers are not cleared; stale rows are masked by out_en gating.
- Line buffers: WIN-1 buffers, each IMG_W x PIX_W, synchronous read.
  - Buffer 0 holds the previous line; buffer k holds line row-1-k.
- Pipeline, stage 0 (accept cycle): read all buffers at col; register pixel, col, row and valid.
- Pipeline, stage 1:
  - Write the stage-0 pixel into buffer 0 at col_d1, and read-data of buffer k into buffer k+1 at col_d1.
  - Shift every window row left one column.
  - Load column WIN-1 as: row WIN-1 = current pixel; row WIN-2-k = buffer k read data.
- The stage-1 write address (col_d1) never equals the stage-0 read address for back-to-back pixels (IMG_W >= 2). No bypass is needed.
- Latency: fixed 2 cycles from accepting in_en to out_en and the updated out_window.
  - Gaps in in_en are allowed anywhere; the pipeline holds state and does not shift on idle cycles.
  - Throughput is 1 pixel/cycle.
- out_en = 1 two cycles after accepting pixel (row,col) only when row >= WIN-1 and col >= WIN-1.
  - No border padding: the first valid window of a frame is at newest pixel (WIN-1, WIN-1).
  - Windows spanning a line wrap (col < WIN-1) are suppressed.
- With out_en=1:
  - out_row = row-(WIN-1)/2 and out_col = col-(WIN-1)/2.
  - out_window(r,c) = pixel(row-(WIN-1)+r, col-(WIN-1)+c). Row 0 is top, column 0 is left.
- When out_en=0, out_window/out_row/out_col hold their last values.
- Reset mid-frame: everything in the reset list returns to its reset value next cycle. No out_en until a new frame has filled WIN-1 lines. Stale line-buffer data never reaches a window with out_en=1.

Test Plan:
- Reset check, with WIN=5, IMG_W=16, IMG_H=12 and in_pix=(row*16+col) mod 256: assert rst for 2 cycles with in_en=1 -> all outputs 0, no out_en.
- Full frame, same parameters, continuous in_en:
  - Exactly (12-4)*(16-4)=96 out_en pulses.
  - The first pulse comes 2 cycles after pixel (4,4) is accepted, with out_row=2, out_col=2, out_window(0,0)=0 and out_window(4,4)=68.
- Gapped input: same frame with in_en toggled by a random 50% pattern -> the same 96 windows with identical contents, each 2 cycles after its accepting in_en.
- Line wrap: check the windows for newest pixels (5,15) and (6,0) -> (5,15) gives out_en with out_window(4,4)=95. For (6,0) through (6,3) there is no out_en.
- Frame overrun / new frame:
  - 20 extra in_en pixels after the last pixel are ignored, with no out_en.
  - A new in_vs rising edge with a simultaneous in_en accepts pixel (0,0). The second frame produces 96 windows, first at centre (2,2).
- Mid-frame reset and WIN=31: with IMG_W=40 and IMG_H=36, assert rst at row 20, then send a fresh frame -> 6*10=60 windows.
  - First window: out_row=15, out_col=15, out_window(15,15)=pixel(15,15).
